// File: rtl/fifo_stream_out.sv
// fifo_stream_out: drains a synchronous FIFO through a 3-entry buffer into a packet stream.
// Define FIFO_STREAM_OUT_CHECKSUM_EN to append a checksum beat after every packet.
module fifo_stream_out #(
    parameter int Data_width = 16,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [Data_width-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic [Data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

`ifdef FIFO_STREAM_OUT_CHECKSUM_EN
    typedef enum logic {STREAM, CKSUM} state_t;
`else
    typedef enum logic {STREAM} state_t;
`endif

    state_t                state_q;
    state_t                state_d;
    logic [Data_width-1:0] mem_q [3];
    logic [1:0]            wr_ptr_q;
    logic [1:0]            rd_ptr_q;
    logic [1:0]            count_q;
    logic                  inflight_q;
    logic                  armed_q;
    logic [7:0]            beat_q;
    logic                  beat_fire;
    logic [2:0]            occupancy;

`ifdef FIFO_STREAM_OUT_CHECKSUM_EN
    logic [Data_width-1:0] sum_q;
`endif

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // In-flight pop reserves a slot so the buffer can never overflow.
    assign occupancy    = {1'b0, count_q} + {2'b00, inflight_q};
    assign fifo_read_en = armed_q && !fifo_empty && (occupancy < 3'd3);

    always_comb begin
        state_d   = state_q;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = mem_q[rd_ptr_q];
        beat_fire = 1'b0;
        unique case (state_q)
            STREAM: begin
                m_valid   = (count_q != 2'd0);
                beat_fire = m_valid && m_ready;
`ifdef FIFO_STREAM_OUT_CHECKSUM_EN
                if (beat_fire && (beat_q == LAST_BEAT)) begin
                    state_d = CKSUM;
                end
`else
                m_last = m_valid && (beat_q == LAST_BEAT);
`endif
            end
`ifdef FIFO_STREAM_OUT_CHECKSUM_EN
            CKSUM: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
                m_data  = sum_q;
                if (m_ready) begin
                    state_d = STREAM;
                end
            end
`endif
            default: begin
                state_d = STREAM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= STREAM;
            armed_q    <= 1'b0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            beat_q     <= 8'd0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            inflight_q <= fifo_read_en;
            count_q    <= count_q + {1'b0, inflight_q} - {1'b0, beat_fire};
            if (inflight_q) begin
                mem_q[wr_ptr_q] <= fifo_data;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (beat_fire) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
                beat_q   <= (beat_q == LAST_BEAT) ? 8'd0 : beat_q + 8'd1;
            end
        end
    end

`ifdef FIFO_STREAM_OUT_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (beat_fire) begin
            sum_q <= sum_q + m_data;
        end else if ((state_q == CKSUM) && m_ready) begin
            sum_q <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out with a behavioural synchronous FIFO in front.
// Expectations follow FIFO_STREAM_OUT_CHECKSUM_EN when the macro is defined.
module tb_fifo_stream_out;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_read_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;

    fifo_stream_out #(.Data_width(DW), .PKT_LEN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fmem [0:127];
    int            wr_idx = 0;
    int            rd_idx = 0;

    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (fifo_read_en && (rd_idx != wr_idx)) begin
            fifo_data <= fmem[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] lg_data [0:255];
    logic          lg_last [0:255];
    int            lg_cyc  [0:255];
    int            rd_cyc  [0:255];
    int            nb = 0;
    int            n_pop = 0;
    int            bad_rd = 0;
    int            bad_hold = 0;
    logic          hold = 1'b0;
    logic [DW-1:0] h_data = '0;
    logic          h_last = 1'b0;

    always @(negedge clk) begin
        if (fifo_read_en && fifo_empty) bad_rd <= bad_rd + 1;
        if (reset) begin
            hold <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                lg_data[nb] <= m_data;
                lg_last[nb] <= m_last;
                lg_cyc[nb]  <= cyc;
                nb          <= nb + 1;
            end
            if (fifo_read_en) begin
                rd_cyc[n_pop] <= cyc;
                n_pop         <= n_pop + 1;
            end
            if (hold && (!m_valid || m_data !== h_data || m_last !== h_last))
                bad_hold <= bad_hold + 1;
            hold   <= m_valid && !m_ready;
            h_data <= m_data;
            h_last <= m_last;
        end
    end

    int            tests = 0;
    int            fails = 0;
    int            base = 0;
    int            pbase = 0;
    int            k = 0;
    logic [DW-1:0] sum = '0;
    logic [DW-1:0] exp_d [$];
    logic          exp_l [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_reset();
        exp_d.delete();
        exp_l.delete();
        k   = 0;
        sum = '0;
    endtask

    task automatic expect_word(input logic [DW-1:0] w);
        exp_d.push_back(w);
`ifdef FIFO_STREAM_OUT_CHECKSUM_EN
        exp_l.push_back(1'b0);
        sum = sum + w;
        if (k == 3) begin
            exp_d.push_back(sum);
            exp_l.push_back(1'b1);
            sum = '0;
        end
`else
        exp_l.push_back(k == 3);
`endif
        k = (k == 3) ? 0 : k + 1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fmem[wr_idx] = w;
        wr_idx++;
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_beats"}, nb - base, exp_d.size());
        for (int i = 0; i < exp_d.size() && i < nb - base; i++) begin
            chk($sformatf("%s_data%0d", tag, i), lg_data[base+i], exp_d[i]);
            chk($sformatf("%s_last%0d", tag, i), lg_last[base+i], exp_l[i]);
        end
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_rden"}, fifo_read_en, 0);
    endtask

    task automatic start(input logic rdy);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_ready = rdy;
        base    = nb;
        pbase   = n_pop;
        exp_reset();
    endtask

    task automatic enter_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int viol;
        int nxt;

        // Full-rate stream with reset-state checks
        for (int i = 0; i < 8; i++) push(DW'(i));
        repeat (3) @(posedge clk);
        chk_zero("reset");
        start(1'b1);
        @(negedge clk);
        chk("rden_first_cycle", fifo_read_en, 0);
        for (int i = 0; i < 8; i++) expect_word(DW'(i));
        repeat (20) @(posedge clk);
        #1;
        check_log("stream");
        chk("stream_latency", lg_cyc[base] - rd_cyc[pbase], 2);
        chk("stream_rate", lg_cyc[base+exp_d.size()-1] - lg_cyc[base],
            exp_d.size() - 1);

        // Backpressure: fill under stall, then 1,0,0 ready pattern
        enter_reset();
        for (int i = 0; i < 8; i++) push(DW'(i));
        start(1'b0);
        for (int i = 0; i < 8; i++) expect_word(DW'(i));
        repeat (8) @(posedge clk);
        #1;
        chk("bp_pops_held", n_pop - pbase, 3);
        viol = 0;
        for (int i = 0; i < 60; i++) begin
            m_ready = (i % 3 == 0);
            @(negedge clk);
            #1;
            if ((n_pop - pbase) - (nb - base) > 3) viol++;
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_log("bp");
        chk("bp_occupancy", viol, 0);
        chk("bp_stable", bad_hold, 0);

        // Empty FIFO, then a single word
        enter_reset();
        start(1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("empty_no_pop", n_pop - pbase, 0);
        chk("empty_no_beat", nb - base, 0);
        push(16'h00A5);
        expect_word(16'h00A5);
        repeat (6) @(posedge clk);
        #1;
        chk("empty_one_pop", n_pop - pbase, 1);
        check_log("empty");
        chk("empty_rden_guard", bad_rd, 0);

`ifdef FIFO_STREAM_OUT_CHECKSUM_EN
        // Checksum beats, including modular wrap
        enter_reset();
        push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
        push(16'hFFFF); push(16'h0002); push(16'h0000); push(16'h0000);
        start(1'b1);
        for (int i = 0; i < 8; i++) expect_word(fmem[wr_idx-8+i]);
        repeat (20) @(posedge clk);
        #1;
        check_log("cksum");
        chk("cksum_a", lg_data[base+4], 16'h000A);
        chk("cksum_b", lg_data[base+9], 16'h0001);
`endif

        // Reset in the middle of a packet
        enter_reset();
        for (int i = 0; i < 12; i++) push(DW'(i));
        start(1'b0);
        repeat (6) @(posedge clk);
        #1;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1'b0;
        expect_word(16'd0);
        expect_word(16'd1);
        check_log("pre_rst");
        reset = 1'b1;
        chk_zero("mid_rst");
        nxt = rd_idx;
        start(1'b1);
        for (int w = nxt; w < wr_idx; w++) expect_word(fmem[w]);
        repeat (25) @(posedge clk);
        #1;
        check_log("post_rst");
        chk("rden_guard_all", bad_rd, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
